fp_add_arbiter: RTL and testbench
=================================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter LAT, default 2, SHALL set the number of BUSY cycles the operands are held on the adder before the result is sampled; legal range 1..4.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operand pair pending.
REQ-005 req0_ready / req1_ready  output  1  requester n's operands are accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32  IEEE-754 single-precision operands.
REQ-007 res_valid  output  1  result is available.
REQ-008 res_ready  input  1  consumer accepts the result.
REQ-009 res_data  output  32  sum a+b, as produced by the shared adder datapath.
REQ-010 res_id  output  1  index of the requester that owns res_data.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The block SHALL share one adder datapath between two requesters, with at most one operation in flight at a time.
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 IDLE -> BUSY on a request handshake.
REQ-015 BUSY -> DONE when cnt == LAT-1.
REQ-016 DONE -> IDLE on res_valid && res_ready.
REQ-017 In IDLE, reqN_ready SHALL be driven combinationally high only for the granted requester, and only when its valid is high; it SHALL be low in BUSY and DONE.
REQ-018 Grant SHALL be round-robin.
REQ-019 With a single requester valid, that requester SHALL be granted.
REQ-020 With both valid, the requester other than last_grant SHALL be granted.
REQ-021 last_grant SHALL update only on a handshake.
REQ-022 On a handshake in cycle T, operands SHALL be registered into op_a/op_b, and the requester index SHALL be registered into res_id, at the edge ending T.
REQ-023 Operands SHALL remain stable on the adder inputs until the result is sampled.
REQ-024 Counter cnt (2 bits) SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-025 The adder output SHALL be registered into res_data at the edge ending the last BUSY cycle.
REQ-026 res_valid SHALL rise in cycle T+LAT+1, which is the latency from handshake to result.
REQ-027 res_valid, res_data and res_id SHALL hold stable while res_valid && !res_ready.
REQ-028 res_valid SHALL drop in the cycle after the result handshake.
REQ-029 No grant SHALL be issued in DONE, even if res_ready and a request coincide; the grant occurs in the following IDLE cycle.
REQ-030 Maximum throughput SHALL be one operation per LAT+2 cycles.
REQ-031 A requester dropping valid while not granted SHALL be legal, and no state SHALL change.
REQ-032 res_data SHALL be passed through unmodified from the datapath, including its infinity/NaN and zero encodings.

Reset
REQ-033 While rst is high, the block SHALL hold the following values:
- state = IDLE
- cnt = 0
- last_grant = 1 (req0 wins first contention)
- op_a = op_b = 0
- res_data = 0, res_id = 0
- res_valid = 0, busy = 0
- req0_ready = req1_ready = 0
REQ-034 Reset asserted in BUSY or DONE SHALL discard the in-flight operation, and no res_valid SHALL follow for it.
REQ-035 The first grant after reset release SHALL occur no earlier than the first edge on which rst is low.

Structure
REQ-036 Package fp_add_pkg SHALL hold the following:
- the state enum {IDLE, BUSY, DONE}
- FP_W = 32
- LAT_MAX = 4
- constants FP_ZERO = 32'h0000_0000 and FP_ONE = 32'h3F80_0000
REQ-037 The block SHALL instantiate the team's existing combinational fp_adder once as its only sub-module; arbitration, FSM and registers SHALL be local.
REQ-038 The RTL SHALL contain no combinational path from res_ready to req0_ready or req1_ready.

Verification
REQ-039 Simple add: req0 with a=0x3F800000, b=0x40000000 and LAT=2 -> res_valid at T+3, res_data=0x40400000, res_id=0.
REQ-040 Contention: req0 and req1 both valid at the first cycle after reset -> req0 served first, then req1; res_id sequence 0,1; req1 receives ready exactly LAT+2 cycles after req0.
REQ-041 Backpressure: res_ready low for 5 cycles in DONE -> res_valid, res_data and res_id stable throughout; no reqN_ready asserted; IDLE one cycle after res_ready rises.
REQ-042 Reset mid-operation: rst pulsed during BUSY -> busy=0 and res_valid=0 immediately; no result emitted for the dropped request; the next request is served normally.
REQ-043 Zero result: a=0x3FC00000, b=0xBFC00000 (1.5 + -1.5) -> res_data=0x00000000.
REQ-044 Solo requester: req1 valid continuously with req0 idle -> req1 granted on every IDLE cycle, with last_grant=1 each time.

Source files
------------

// File: rtl/fp_add_pkg.sv
// Shared types and constants for the two-requester floating-point add arbiter.
package fp_add_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int              FP_W    = 32;
    localparam int              LAT_MAX = 4;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// gradual underflow, canonical quiet NaN for invalid operations.
module fp_adder
    import fp_add_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] sum
);
    logic [FP_W-1:0] big, sml;
    logic [7:0]      big_e, sml_e, diff;
    logic [26:0]     big_m, sml_m, sml_mask, aligned, norm;
    logic [27:0]     raw;
    logic [8:0]      exp_n, shamt;
    logic [4:0]      lz;
    logic [24:0]     rounded;
    logic            a_nan, b_nan, a_inf, b_inf, round_up;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        sum      = FP_ZERO;
        sml_mask = '0;
        lz       = 5'd27;
        shamt    = '0;
        norm     = '0;
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_inf = (&a[30:23]) && !(|a[22:0]);
        b_inf = (&b[30:23]) && !(|b[22:0]);
        if (a[30:0] < b[30:0]) begin
            big = b;
            sml = a;
        end else begin
            big = a;
            sml = b;
        end
        big_e = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        sml_e = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        big_m = {|big[30:23], big[22:0], 3'b000};
        sml_m = {|sml[30:23], sml[22:0], 3'b000};
        diff  = big_e - sml_e;
        // Bits shifted out of the smaller operand collapse into a sticky bit.
        if (diff >= 8'd27) begin
            aligned = {26'd0, |sml_m};
        end else begin
            sml_mask = (27'd1 << diff) - 27'd1;
            aligned  = (sml_m >> diff) | {26'd0, |(sml_m & sml_mask)};
        end
        raw = (big[31] ^ sml[31]) ? ({1'b0, big_m} - {1'b0, aligned})
                                  : ({1'b0, big_m} + {1'b0, aligned});
        exp_n = {1'b0, big_e};
        if (raw[27]) begin
            norm  = raw[27:1] | {26'd0, raw[0]};
            exp_n = exp_n + 9'd1;
        end else begin
            for (int i = 0; i < 27; i++) if (raw[i]) lz = 5'(26 - i);
            shamt = ({4'd0, lz} < exp_n - 9'd1) ? {4'd0, lz} : exp_n - 9'd1;
            norm  = raw[26:0] << shamt;
            exp_n = exp_n - shamt;
        end
        round_up = norm[2] && ((|norm[1:0]) || norm[3]);
        rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rounded[24]) begin
            rounded = rounded >> 1;
            exp_n   = exp_n + 9'd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) sum = FP_QNAN;
        else if (a_inf)              sum = a;
        else if (b_inf)              sum = b;
        else if (raw == 28'd0)       sum = {big[31] & sml[31], 31'd0};
        else if (exp_n >= 9'd255)    sum = {big[31], 8'hFF, 23'd0};
        else sum = {big[31], rounded[23] ? exp_n[7:0] : 8'd0, rounded[22:0]};
    end
endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one fp_adder between two requesters,
// one operation in flight, result held until the consumer accepts it.
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [FP_W-1:0] req0_a,
    input  logic [FP_W-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [FP_W-1:0] req1_a,
    input  logic [FP_W-1:0] req1_b,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [FP_W-1:0] res_data,
    output logic            res_id,
    output logic            busy
);
    localparam int         LAT_C    = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
    localparam logic [1:0] CNT_LAST = 2'(LAT_C - 1);

    state_t          state;
    logic [1:0]      cnt;
    logic            last_grant, grant, hs;
    logic [FP_W-1:0] op_a, op_b, sum;

    // Under contention the requester not served last wins; ready never depends on res_ready.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        hs         = (state == IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = hs && !grant;
        req1_ready = hs && grant;
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    fp_adder u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            op_a       <= FP_ZERO;
            op_b       <= FP_ZERO;
            res_data   <= FP_ZERO;
            res_id     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (hs) begin
                    state      <= BUSY;
                    cnt        <= '0;
                    last_grant <= grant;
                    res_id     <= grant;
                    op_a       <= grant ? req1_a : req0_a;
                    op_b       <= grant ? req1_b : req0_b;
                end
                BUSY: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == CNT_LAST) begin
                        state    <= DONE;
                        res_data <= sum;
                    end
                end
                DONE:    if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: directed scenarios plus a randomized
// run against a timestamp-based transaction model.
module tb_fp_add_arbiter;
    import fp_add_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        res_valid, res_id, busy;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    int          n_checks = 0, n_pass = 0;

    fp_add_arbiter #(.LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Exact single-precision encoding of an integer with magnitude below 2^24.
    function automatic logic [31:0] int_to_fp(input int v);
        logic [31:0] r = 32'd0;
        longint      m;
        int          e = 0;
        if (v == 0) return 32'd0;
        m = (v < 0) ? -longint'(v) : longint'(v);
        while ((m >> (e + 1)) != 0) e++;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + e);
        r[22:0]  = 23'(m << (23 - e));
        return r;
    endfunction

    function automatic int rand_int();
        int mag = int'($urandom_range(0, 1 << $urandom_range(0, 20)));
        return ($urandom_range(0, 1) != 0) ? -mag : mag;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_sum, input string tag);
        int w = 0, lat = 1;
        res_ready = 1'b1;
        if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        #1;
        while ((id ? req1_ready : req0_ready) !== 1'b1 && w < 20) begin @(posedge clk); #2; w++; end
        n_checks++;
        if (w >= 20) $display("FAIL %s_grant: no ready after %0d cycles, expected within 20", tag, w);
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        while (res_valid !== 1'b1 && lat < 20) begin @(posedge clk); #2; lat++; end
        n_checks++;
        if (lat != LAT + 1) $display("FAIL %s_latency: got %0d expected %0d", tag, lat, LAT + 1);
        else n_pass++;
        n_checks++;
        if (res_data !== exp_sum) $display("FAIL %s_data: got %h expected %h", tag, res_data, exp_sum);
        else n_pass++;
        n_checks++;
        if (res_id !== id) $display("FAIL %s_id: got %b expected %b", tag, res_id, id);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        else n_pass++;
        n_checks++;
        if ({res_valid, busy} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {res_valid, busy});
        else n_pass++;
        n_checks++;
        if ({res_id, res_data} !== 33'd0) $display("FAIL reset_result: got %h expected 0", {res_id, res_data});
        else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_simple();
        run_op(1'b0, FP_ONE, 32'h4000_0000, 32'h4040_0000, "simple");
    endtask

    task automatic test_zero();
        run_op(1'b0, 32'h3FC0_0000, 32'hBFC0_0000, FP_ZERO, "zero");
    endtask

    task automatic test_specials();
        run_op(1'b1, 32'h7F80_0000, FP_ONE,       32'h7F80_0000, "inf_plus_one");
        run_op(1'b0, 32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, "inf_minus_inf");
        run_op(1'b1, 32'h7FC0_0000, FP_ZERO,      32'h7FC0_0000, "nan_pass");
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, "neg_zero");
    endtask

    task automatic test_contention();
        int   t0 = -1, t1 = -1, nres = 0;
        logic id0 = 1'bx, id1 = 1'bx;
        logic [31:0] d0 = '0, d1 = '0;
        bit   r0, r1;
        req0_a = int_to_fp(10);  req0_b = int_to_fp(-3);
        req1_a = int_to_fp(100); req1_b = int_to_fp(28);
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        pulse_reset();
        #1;
        for (int c = 0; c < 30 && nres < 2; c++) begin
            r0 = req0_ready; r1 = req1_ready;
            if (r0 && t0 < 0) t0 = c;
            if (r1 && t1 < 0) t1 = c;
            if (res_valid === 1'b1) begin
                if (nres == 0) begin id0 = res_id; d0 = res_data; end
                else           begin id1 = res_id; d1 = res_data; end
                nres++;
            end
            @(posedge clk); #1;
            if (r0) req0_valid = 1'b0;
            if (r1) req1_valid = 1'b0;
            #1;
        end
        n_checks++;
        if (t0 != 0) $display("FAIL cont_first_grant: got cycle %0d expected 0", t0);
        else n_pass++;
        n_checks++;
        if (t1 - t0 != LAT + 2) $display("FAIL cont_spacing: got %0d expected %0d", t1 - t0, LAT + 2);
        else n_pass++;
        n_checks++;
        if ({id0, id1} !== 2'b01) $display("FAIL cont_order: got %b expected 01", {id0, id1});
        else n_pass++;
        n_checks++;
        if ({d0, d1} !== {int_to_fp(7), int_to_fp(128)})
            $display("FAIL cont_data: got %h %h expected %h %h", d0, d1, int_to_fp(7), int_to_fp(128));
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d = int_to_fp(12);
        int w = 0;
        res_ready = 1'b0; req0_valid = 1'b0;
        req1_a = int_to_fp(5); req1_b = int_to_fp(7); req1_valid = 1'b1;
        #1;
        while (req1_ready !== 1'b1 && w < 20) begin @(posedge clk); #2; w++; end
        n_checks++;
        if (w >= 20) $display("FAIL bp_grant: no ready after %0d cycles, expected within 20", w);
        else n_pass++;
        @(posedge clk); #1;
        req1_valid = 1'b0; req0_a = FP_ONE; req0_b = FP_ONE; req0_valid = 1'b1;
        #1; w = 0;
        while (res_valid !== 1'b1 && w < 20) begin @(posedge clk); #2; w++; end
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, exp_d})
                $display("FAIL bp_hold: cycle %0d got %h expected %h", c, {res_valid, res_id, res_data}, {1'b1, 1'b1, exp_d});
            else n_pass++;
            n_checks++;
            if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL bp_ready: cycle %0d got %b expected 00", c, {req0_ready, req1_ready});
            else n_pass++;
            @(posedge clk); #2;
        end
        res_ready = 1'b1;
        #1;
        n_checks++;
        if ({res_valid, req0_ready} !== 2'b10) $display("FAIL bp_done_nogrant: got %b expected 10", {res_valid, req0_ready});
        else n_pass++;
        @(posedge clk); #2;
        n_checks++;
        if ({busy, res_valid, req0_ready} !== 3'b001) $display("FAIL bp_idle: got %b expected 001", {busy, res_valid, req0_ready});
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #1; w = 0;
        while (res_valid !== 1'b1 && w < 20) begin @(posedge clk); #2; w++; end
        n_checks++;
        if ({res_id, res_data} !== {1'b0, 32'h4000_0000}) $display("FAIL bp_next: got %h expected %h", {res_id, res_data}, {1'b0, 32'h4000_0000});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        res_ready = 1'b1; req0_a = int_to_fp(3); req0_b = int_to_fp(4); req0_valid = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) $display("FAIL rstmid_grant: got %b expected 1", req0_ready);
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL rstmid_busy: got %b expected 1", busy);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, res_valid} !== 2'b00) $display("FAIL rstmid_clear: got %b expected 00", {busy, res_valid});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < LAT + 4; c++) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL rstmid_dropped: got res_valid 1 expected 0");
        else n_pass++;
        run_op(1'b0, int_to_fp(2), int_to_fp(3), int_to_fp(5), "rstmid_next");
    endtask

    task automatic test_solo();
        int w = 0;
        int p = LAT + 2;
        req1_a = FP_ONE; req1_b = FP_ONE; req1_valid = 1'b1; req0_valid = 1'b0; res_ready = 1'b1;
        #1;
        for (int c = 0; c < 3 * p; c++) begin
            n_checks++;
            if (req1_ready !== ((c % p) == 0)) $display("FAIL solo_ready: cycle %0d got %b expected %b", c, req1_ready, (c % p) == 0);
            else n_pass++;
            if (res_valid === 1'b1) begin
                n_checks++;
                if (res_id !== 1'b1) $display("FAIL solo_id: cycle %0d got %b expected 1", c, res_id);
                else n_pass++;
            end
            @(posedge clk); #2;
        end
        req0_a = FP_ONE; req0_b = FP_ONE; req0_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL solo_then_both: got %b expected 10", {req0_ready, req1_ready});
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        while (res_valid !== 1'b1 && w < 20) begin @(posedge clk); #2; w++; end
        n_checks++;
        if ({res_id, res_data} !== {1'b0, 32'h4000_0000}) $display("FAIL solo_last: got %h expected %h", {res_id, res_data}, {1'b0, 32'h4000_0000});
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // Model: an operation accepted at cycle h shows its result from cycle h+LAT+1
    // until consumed; grants only happen when nothing is in flight.
    task automatic test_random();
        bit          in_flight = 1'b0, lastg = 1'b1, exp_id = 1'b0;
        bit          v0, v1, win, grant_ok, rv;
        int          hs_c = 0, a0, b0, a1, b1;
        logic [31:0] exp_d = '0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            a0 = rand_int(); b0 = rand_int(); a1 = rand_int(); b1 = rand_int();
            req0_valid = v0; req1_valid = v1;
            req0_a = int_to_fp(a0); req0_b = int_to_fp(b0);
            req1_a = int_to_fp(a1); req1_b = int_to_fp(b1);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            rv       = in_flight && (c >= hs_c + LAT + 1);
            win      = (v0 && v1) ? !lastg : v1;
            grant_ok = !in_flight && (v0 || v1);
            n_checks++;
            if ({req0_ready, req1_ready} !== {grant_ok && !win, grant_ok && win})
                $display("FAIL rnd_ready: cycle %0d got %b expected %b", c, {req0_ready, req1_ready}, {grant_ok && !win, grant_ok && win});
            else n_pass++;
            n_checks++;
            if ({res_valid, busy} !== {rv, in_flight})
                $display("FAIL rnd_flags: cycle %0d got %b expected %b", c, {res_valid, busy}, {rv, in_flight});
            else n_pass++;
            if (rv) begin
                n_checks++;
                if ({res_id, res_data} !== {exp_id, exp_d})
                    $display("FAIL rnd_result: cycle %0d got %h expected %h", c, {res_id, res_data}, {exp_id, exp_d});
                else n_pass++;
            end
            if (rv && res_ready) begin
                in_flight = 1'b0;
            end else if (grant_ok) begin
                in_flight = 1'b1;
                hs_c      = c;
                lastg     = win;
                exp_id    = win;
                exp_d     = int_to_fp(win ? a1 + b1 : a0 + b0);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_simple();
        test_zero();
        test_specials();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_solo();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at 2000000, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
